switch_allocator: RTL and testbench
===================================

// Module: switch_allocator
// PURPOSE
//   Per-output round-robin allocator that drives select_array of the xbar.
//   Each input port raises a one-hot request for one output; every output grants
//   at most one input per cycle, gated by downstream readiness. Sits between the
//   input buffers and the xbar of each flattened-butterfly router.
// PARAMETERS
//   INPORT   5  number of requesting input ports
//   OUTPORT  5  number of output ports (one arbiter each)
// PORTS
//   clk          in   1                clock; all state updates on rising edge
//   rst          in   1                reset, asynchronous, active-high
//   req_i        in   INPORT*OUTPORT   bit i*OUTPORT+o: input i requests output o
//   tail_i       in   INPORT           input i's current flit is a packet tail
//   out_ready_i  in   OUTPORT          output o can accept a flit this cycle
//   grant_o      out  INPORT           input i transfers a flit this cycle
//   select_array out  OUTPORT*INPORT   bit o*INPORT+i: xbar routes input i to out o
// BEHAVIOUR
//   - Vectors are [0:N-1] ascending; index 0 is the MSB position.
//   - Grants are combinational from req_i/tail_i/out_ready_i and registered state
//     (0-cycle latency); a flit moves in a cycle where grant_o[i]=1.
//   - Request filtering: if input i sets >1 req bit, only the lowest-index output
//     is considered; others ignored that cycle.
//   - State per output o: ptr[o] (clog2(INPORT) bits, highest-priority input),
//     and, when SA_PKT_LOCK_EN is defined, lock_v[o] (1 bit) + lock_id[o].
//   - Arbitration (unlocked output o, out_ready_i[o]=1): winner = first requesting
//     input at ptr[o], ptr[o]+1, ... mod INPORT. No requester -> no grant.
//   - Pointer update: on a grant that ends the arbitration epoch, ptr[o] <=
//     (winner+1) mod INPORT; wraps INPORT-1 -> 0. Otherwise ptr[o] holds.
//   - out_ready_i[o]=0: output o grants nothing; ptr/lock state held.
//   - grant_o[i] = OR over o of select bit (o,i); at most one bit per input is
//     ever set because of request filtering; select_array one-hot or zero per output.
//   - Reset (any time, incl. mid-packet): ptr[o]=0, lock_v[o]=0; outputs are
//     combinational, so with state cleared they follow req_i immediately after reset.
//   - Allocation is independent per output; simultaneous grants on distinct
//     outputs to distinct inputs in the same cycle are normal.
// CONFIGURATION
//   SA_PKT_LOCK_EN defined: wormhole lock. Grant to input i on output o with
//     tail_i[i]=0 sets lock_v[o]=1, lock_id[o]=i; while locked, only lock_id may be
//     granted (needs its req bit and out_ready_i[o]); other requests ignored. A
//     granted flit with tail_i=1 clears the lock and advances ptr[o]. Holder
//     dropping req mid-packet -> bubble, lock held. Grant with tail_i=1 on an
//     unlocked output = single-flit packet: no lock, ptr advances.
//   SA_PKT_LOCK_EN undefined: tail_i ignored, no lock state; every grant ends
//     the epoch and advances ptr[o] (flit-level round-robin).
// TESTING (INPORT=OUTPORT=5)
//   1 reset, inputs 1,3 request out 2, ready -> grant_o=01000, select bit 2*5+1;
//     next cycle ptr[2]=2 -> input 3 granted (grant_o=00010).
//   2 ptr[4]=4, inputs 0,4 request out 4 -> input 4 wins; ptr[4] wraps to 0,
//     next cycle input 0 wins.
//   3 out_ready_i[2]=0 with requests pending 3 cycles -> no grant, ptr unchanged;
//     ready=1 -> expected winner granted.
//   4 LOCK_EN: input 1 sends 3-flit pkt (tail on 3rd) to out 0 while input 2 also
//     requests -> input 1 granted 3 cycles, input 2 on 4th; without macro they alternate.
//   5 LOCK_EN: assert rst mid-packet (lock on out 0 held by input 1) -> lock cleared,
//     next cycle input 0 request to out 0 granted immediately.
//   6 input 3 sets req bits for outs 1 and 4 -> only out 1 considered; out 4 idle.

Source files
------------

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin allocator driving the xbar select_array.
// Each input's request is reduced to its lowest-index output; each output then
// picks one requester starting at its priority pointer, gated by out_ready_i.
// Grants are combinational from the current inputs and the registered pointers.
// Optional build macro SA_PKT_LOCK_EN enables a wormhole lock: an output stays
// dedicated to one input from its first non-tail flit until its tail flit.
module switch_allocator #(
  parameter int INPORT  = 5,
  parameter int OUTPORT = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:INPORT*OUTPORT-1] req_i,
  input  logic [0:INPORT-1]         tail_i,
  input  logic [0:OUTPORT-1]        out_ready_i,
  output logic [0:INPORT-1]         grant_o,
  output logic [0:OUTPORT*INPORT-1] select_array
);

  localparam int PW = (INPORT > 1) ? $clog2(INPORT) : 1;
  localparam logic [PW-1:0] LAST_IN = PW'(INPORT - 1);

  // Requests after keeping only the lowest-index output per input
  logic [0:INPORT*OUTPORT-1] req_f;

`ifndef SA_PKT_LOCK_EN
  // Tail marks only matter for packet locking
  logic unused_tail;
  assign unused_tail = ^tail_i;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < INPORT; gi++) begin : g_filter
      logic [0:OUTPORT-1] row_f;

      // Pass only the first (lowest-index) requested output of this input
      always_comb begin
        logic seen;
        seen  = 1'b0;
        row_f = '0;
        for (int o = 0; o < OUTPORT; o++) begin
          row_f[o] = req_i[gi*OUTPORT + o] & ~seen;
          seen     = seen | req_i[gi*OUTPORT + o];
        end
      end

      assign req_f[gi*OUTPORT +: OUTPORT] = row_f;
    end

    for (gi = 0; gi < OUTPORT; gi++) begin : g_out
      logic [0:INPORT-1] col;
      logic [0:INPORT-1] sel;
      logic [PW-1:0]     ptr_reg;
      logic [PW-1:0]     ptr_next;
      logic [PW-1:0]     win;
      logic              found;
      logic [PW-1:0]     gnt_id;
      logic [PW-1:0]     gnt_inc;
      logic              grant_v;

      // Gather the filtered requests aimed at this output
      always_comb begin
        col = '0;
        for (int i = 0; i < INPORT; i++) begin
          col[i] = req_f[i*OUTPORT + gi];
        end
      end

      // Round-robin search: first requester at or above ptr, else wrap to the bottom
      always_comb begin
        win   = '0;
        found = 1'b0;
        for (int j = 0; j < INPORT; j++) begin
          if (!found && col[j] && (PW'(j) >= ptr_reg)) begin
            win   = PW'(j);
            found = 1'b1;
          end
        end
        for (int j = 0; j < INPORT; j++) begin
          if (!found && col[j]) begin
            win   = PW'(j);
            found = 1'b1;
          end
        end
      end

`ifdef SA_PKT_LOCK_EN
      logic          lock_v_reg;
      logic          lock_v_next;
      logic [PW-1:0] lock_id_reg;
      logic [PW-1:0] lock_id_next;

      // A locked output serves only its holder; otherwise the round-robin winner
      always_comb begin
        gnt_id  = lock_v_reg ? lock_id_reg : win;
        grant_v = out_ready_i[gi] & (lock_v_reg ? col[lock_id_reg] : found);
      end

      // Tail flit closes the epoch and advances ptr; a non-tail flit (re)locks
      always_comb begin
        ptr_next     = ptr_reg;
        lock_v_next  = lock_v_reg;
        lock_id_next = lock_id_reg;
        if (grant_v) begin
          if (tail_i[gnt_id]) begin
            lock_v_next = 1'b0;
            ptr_next    = gnt_inc;
          end else begin
            lock_v_next  = 1'b1;
            lock_id_next = gnt_id;
          end
        end
      end

      // Lock state register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lock_v_reg  <= 1'b0;
          lock_id_reg <= '0;
        end else begin
          lock_v_reg  <= lock_v_next;
          lock_id_reg <= lock_id_next;
        end
      end
`else
      // Flit-level round-robin: any ready output grants its winner
      always_comb begin
        gnt_id  = win;
        grant_v = out_ready_i[gi] & found;
      end

      // Every grant ends the epoch and moves priority past the winner
      always_comb begin
        ptr_next = grant_v ? gnt_inc : ptr_reg;
      end
`endif

      assign gnt_inc = (gnt_id == LAST_IN) ? '0 : gnt_id + PW'(1);

      // One-hot select for the granted input, zero when nothing moves
      always_comb begin
        sel = '0;
        if (grant_v) begin
          sel[gnt_id] = 1'b1;
        end
      end

      // Priority pointer register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ptr_reg <= '0;
        end else begin
          ptr_reg <= ptr_next;
        end
      end

      assign select_array[gi*INPORT +: INPORT] = sel;
    end

    for (gi = 0; gi < INPORT; gi++) begin : g_grant
      logic g;

      // An input moves a flit if any output selected it
      always_comb begin
        g = 1'b0;
        for (int o = 0; o < OUTPORT; o++) begin
          g = g | select_array[o*INPORT + gi];
        end
      end

      assign grant_o[gi] = g;
    end
  endgenerate

endmodule

// File: tb/tb_switch_allocator.sv
// Testbench for switch_allocator (INPORT=OUTPORT=5): directed scenarios plus a
// randomized run checked against a queue-free behavioural model of the rules.
module tb_switch_allocator;
  localparam int NI = 5;
  localparam int NO = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [0:NI*NO-1] req_i = '0;
  logic [0:NI-1]    tail_i = '0;
  logic [0:NO-1]    out_ready_i = '1;
  logic [0:NI-1]    grant_o;
  logic [0:NO*NI-1] select_array;

  int n_cmp = 0;
  int n_err = 0;

  switch_allocator #(.INPORT(NI), .OUTPORT(NO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .tail_i       (tail_i),
    .out_ready_i  (out_ready_i),
    .grant_o      (grant_o),
    .select_array (select_array)
  );

  always #5 clk = ~clk;

  function automatic logic [0:NI*NO-1] sel_of(input int o, input int i);
    logic [0:NI*NO-1] s;
    s = '0;
    s[o*NI + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [0:NI-1] gnt_of(input int i);
    logic [0:NI-1] g;
    g = '0;
    g[i] = 1'b1;
    return g;
  endfunction

  task automatic clear_in();
    req_i       = '0;
    tail_i      = '0;
    out_ready_i = '1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [0:NI-1] eg;
    @(negedge clk);
    clear_in();
    rst = 1'b1;
    #1;
    $display("reset: grant=%b sel=%b", grant_o, select_array);
    n_cmp++;
    if (grant_o !== '0) begin
      n_err++; $display("FAIL reset_grant got=%b want=%b", grant_o, 5'b0);
    end
    n_cmp++;
    if (select_array !== '0) begin
      n_err++; $display("FAIL reset_sel got=%b want=0", select_array);
    end
    @(negedge clk);
    rst = 1'b0;
    req_i[2*NO + 0] = 1'b1;
    #1;
    eg = gnt_of(2);
    $display("reset: lone input 2 grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL reset_lone got=%b want=%b", grant_o, eg);
    end
    // ptr[0] now 3; an async pulse must return it to 0 without a clock edge
    @(negedge clk);
    clear_in();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    req_i[0*NO + 0] = 1'b1;
    req_i[4*NO + 0] = 1'b1;
    #1;
    eg = gnt_of(0);
    $display("reset: after async pulse grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL reset_async got=%b want=%b", grant_o, eg);
    end
  endtask

  task automatic test_basic_rr();
    logic [0:NI-1] eg;
    apply_reset();
    @(negedge clk);
    req_i[1*NO + 2] = 1'b1;
    req_i[3*NO + 2] = 1'b1;
    #1;
    eg = 5'b01000;
    $display("basic: c1 grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL basic_c1_grant got=%b want=%b", grant_o, eg);
    end
    n_cmp++;
    if (select_array !== sel_of(2, 1)) begin
      n_err++; $display("FAIL basic_c1_sel got=%b want=%b", select_array, sel_of(2, 1));
    end
    @(negedge clk);
    #1;
    eg = 5'b00010;
    $display("basic: c2 grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL basic_c2_grant got=%b want=%b", grant_o, eg);
    end
    n_cmp++;
    if (select_array !== sel_of(2, 3)) begin
      n_err++; $display("FAIL basic_c2_sel got=%b want=%b", select_array, sel_of(2, 3));
    end
  endtask

  task automatic test_wrap();
    logic [0:NI-1] eg;
    apply_reset();
    @(negedge clk);
    req_i[3*NO + 4] = 1'b1;
    #1;
    eg = 5'b00010;
    $display("wrap: setup grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL wrap_setup got=%b want=%b", grant_o, eg);
    end
    @(negedge clk);
    clear_in();
    req_i[0*NO + 4] = 1'b1;
    req_i[4*NO + 4] = 1'b1;
    #1;
    eg = 5'b00001;
    $display("wrap: ptr4 grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL wrap_top got=%b want=%b", grant_o, eg);
    end
    @(negedge clk);
    #1;
    eg = 5'b10000;
    $display("wrap: ptr0 grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL wrap_zero got=%b want=%b", grant_o, eg);
    end
    n_cmp++;
    if (select_array !== sel_of(4, 0)) begin
      n_err++; $display("FAIL wrap_sel got=%b want=%b", select_array, sel_of(4, 0));
    end
  endtask

  task automatic test_not_ready();
    logic [0:NI-1] eg;
    apply_reset();
    @(negedge clk);
    req_i[1*NO + 2] = 1'b1;
    #1;
    eg = 5'b01000;
    $display("stall: setup grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL stall_setup got=%b want=%b", grant_o, eg);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_in();
      req_i[0*NO + 2] = 1'b1;
      req_i[3*NO + 2] = 1'b1;
      out_ready_i[2]  = 1'b0;
      #1;
      $display("stall: cycle %0d grant=%b", c, grant_o);
      n_cmp++;
      if (grant_o !== '0 || select_array !== '0) begin
        n_err++; $display("FAIL stall_c%0d got=%b/%b want=0", c, grant_o, select_array);
      end
    end
    @(negedge clk);
    out_ready_i[2] = 1'b1;
    #1;
    eg = 5'b00010;
    $display("stall: released grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL stall_release got=%b want=%b", grant_o, eg);
    end
  endtask

  task automatic test_filter();
    logic [0:NI-1]    eg;
    logic [0:NI*NO-1] es;
    apply_reset();
    @(negedge clk);
    req_i[3*NO + 1] = 1'b1;
    req_i[3*NO + 4] = 1'b1;
    req_i[4*NO + 4] = 1'b1;
    #1;
    eg = 5'b00011;
    es = sel_of(1, 3) | sel_of(4, 4);
    $display("filter: grant=%b sel=%b", grant_o, select_array);
    n_cmp++;
    if (grant_o !== eg) begin
      n_err++; $display("FAIL filter_grant got=%b want=%b", grant_o, eg);
    end
    n_cmp++;
    if (select_array !== es) begin
      n_err++; $display("FAIL filter_sel got=%b want=%b", select_array, es);
    end
  endtask

  task automatic test_pkt_lock();
    int            exp_w[4];
`ifdef SA_PKT_LOCK_EN
    exp_w = '{1, 1, 1, 2};
`else
    exp_w = '{1, 2, 1, 2};
`endif
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_in();
      req_i[2*NO + 0] = 1'b1;
      if (c < 3) req_i[1*NO + 0] = 1'b1;
      tail_i[1] = (c == 2);
      #1;
      $display("pkt: cycle %0d grant=%b", c, grant_o);
      n_cmp++;
      if (grant_o !== gnt_of(exp_w[c])) begin
        n_err++; $display("FAIL pkt_c%0d got=%b want=%b", c, grant_o, gnt_of(exp_w[c]));
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    @(negedge clk);
    req_i[1*NO + 0] = 1'b1;
    #1;
    $display("midrst: head grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== gnt_of(1)) begin
      n_err++; $display("FAIL midrst_head got=%b want=%b", grant_o, gnt_of(1));
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    req_i[0*NO + 0] = 1'b1;
    #1;
    $display("midrst: after reset grant=%b", grant_o);
    n_cmp++;
    if (grant_o !== gnt_of(0)) begin
      n_err++; $display("FAIL midrst_after got=%b want=%b", grant_o, gnt_of(0));
    end
  endtask

  task automatic test_random();
    int               m_ptr[NO];
    int               m_lv[NO];
    int               m_lid[NO];
    int               want_o[NI];
    int               win[NO];
    logic [0:NI-1]    eg;
    logic [0:NI*NO-1] es;
    apply_reset();
    for (int o = 0; o < NO; o++) begin
      m_ptr[o] = 0; m_lv[o] = 0; m_lid[o] = 0;
    end
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < NI*NO; k++) req_i[k] = ($urandom_range(0, 99) < 25);
      for (int i = 0; i < NI; i++) tail_i[i] = ($urandom_range(0, 99) < 40);
      for (int o = 0; o < NO; o++) out_ready_i[o] = ($urandom_range(0, 99) < 80);
      if (rst) begin
        for (int o = 0; o < NO; o++) begin
          m_ptr[o] = 0; m_lv[o] = 0; m_lid[o] = 0;
        end
      end
      // Each input's effective destination: its lowest requested output
      for (int i = 0; i < NI; i++) begin
        want_o[i] = -1;
        for (int o = NO - 1; o >= 0; o--) if (req_i[i*NO + o]) want_o[i] = o;
      end
      eg = '0;
      es = '0;
      for (int o = 0; o < NO; o++) begin
        win[o] = -1;
        if (out_ready_i[o]) begin
          if (m_lv[o] != 0) begin
            if (want_o[m_lid[o]] == o) win[o] = m_lid[o];
          end else begin
            for (int k = NI - 1; k >= 0; k--) begin
              if (want_o[(m_ptr[o] + k) % NI] == o) win[o] = (m_ptr[o] + k) % NI;
            end
          end
        end
        if (win[o] >= 0) begin
          eg[win[o]] = 1'b1;
          es[o*NI + win[o]] = 1'b1;
        end
      end
      #1;
      $display("rand %0d: rst=%0d grant=%b", t, rst, grant_o);
      n_cmp++;
      if (grant_o !== eg) begin
        n_err++; $display("FAIL rand_grant t=%0d got=%b want=%b", t, grant_o, eg);
      end
      n_cmp++;
      if (select_array !== es) begin
        n_err++; $display("FAIL rand_sel t=%0d got=%b want=%b", t, select_array, es);
      end
      if (!rst) begin
        for (int o = 0; o < NO; o++) begin
          if (win[o] >= 0) begin
`ifdef SA_PKT_LOCK_EN
            if (tail_i[win[o]]) begin
              m_lv[o]  = 0;
              m_ptr[o] = (win[o] + 1) % NI;
            end else begin
              m_lv[o]  = 1;
              m_lid[o] = win[o];
            end
`else
            m_ptr[o] = (win[o] + 1) % NI;
`endif
          end
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    test_reset();
    test_basic_rr();
    test_wrap();
    test_not_ready();
    test_filter();
    test_pkt_lock();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
